// File: rtl/divider.sv
// Iterative radix-2 restoring integer divider for RV64M/RV32M
// (DIV, DIVU, REM, REMU and their W variants), one quotient bit per clock.
// Divide-by-zero and signed overflow finish one cycle after accept.
// Optional macro DIVIDER_EARLY_OUT_EN: a divisor whose magnitude exceeds the
// dividend's also finishes in one cycle. Results are identical in both builds.
module divider #(
  parameter int XLEN = 64,
  parameter int XMSB = XLEN - 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic            req_w,
  input  logic [XMSB:0]   req_op1,
  input  logic [XMSB:0]   req_op2,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XMSB:0]   result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [XMSB:0] rem_q;
  logic [XMSB:0] dvd_q;
  logic [XMSB:0] dvs_q;
  logic [6:0]    cnt_q;
  logic          is_rem_q;
  logic          neg_q_q;
  logic          neg_r_q;
  logic          w_q;

  logic          is_signed;
  logic          is_rem;
  logic          wop;
  logic [XMSB:0] op1x;
  logic [XMSB:0] op2x;
  logic [XMSB:0] mag1;
  logic [XMSB:0] mag2;
  logic [XMSB:0] minval;
  logic [XMSB:0] spec_raw;
  logic [XMSB:0] spec_res;
  logic          sign1;
  logic          sign2;
  logic          div_zero;
  logic          ovf;
  logic          early;

  logic [XLEN:0] shifted;
  logic          fits;
  logic [XMSB:0] rem_n;
  logic [XMSB:0] dvd_n;
  logic [XMSB:0] q_raw;
  logic [XMSB:0] q_fix;
  logic [XMSB:0] r_fix;
  logic [XMSB:0] sel;
  logic [XMSB:0] fin;

  assign req_ready = (state == IDLE);
  assign res_valid = (state == DONE);

  // Request decode, W operand extension, magnitudes and special-case detection
  always_comb begin
    is_signed = req_funct3[2] & ~req_funct3[0];
    is_rem    = req_funct3[2] & req_funct3[1];
    wop       = (XLEN == 64) && req_w;
    op1x      = req_op1;
    op2x      = req_op2;
    if (wop) begin
      op1x = is_signed ? XLEN'($signed(req_op1[31:0])) : XLEN'(req_op1[31:0]);
      op2x = is_signed ? XLEN'($signed(req_op2[31:0])) : XLEN'(req_op2[31:0]);
    end
    // After extension bit XMSB carries the operand sign in both widths
    sign1    = is_signed & op1x[XMSB];
    sign2    = is_signed & op2x[XMSB];
    mag1     = sign1 ? (-op1x) : op1x;
    mag2     = sign2 ? (-op2x) : op2x;
    minval   = wop ? XLEN'($signed(32'h8000_0000)) : {1'b1, {XMSB{1'b0}}};
    div_zero = (op2x == '0);
    ovf      = is_signed && (op1x == minval) && (op2x == '1);
`ifdef DIVIDER_EARLY_OUT_EN
    early    = (mag2 > mag1) && !div_zero;
`else
    early    = 1'b0;
`endif
    if (div_zero) begin
      spec_raw = is_rem ? op1x : '1;
    end else if (ovf) begin
      spec_raw = is_rem ? '0 : op1x;
    end else begin
      spec_raw = is_rem ? op1x : '0;
    end
    spec_res = wop ? XLEN'($signed(spec_raw[31:0])) : spec_raw;
  end

  // One restoring step plus the sign fixup applied on the final step
  always_comb begin
    shifted = {rem_q, dvd_q[XMSB]};
    fits    = (shifted >= {1'b0, dvs_q});
    rem_n   = fits ? XLEN'(shifted - {1'b0, dvs_q}) : shifted[XMSB:0];
    dvd_n   = {dvd_q[XMSB-1:0], fits};
    // W operands were pre-shifted into the top half, so the quotient
    // accumulates in the low 32 bits after 32 steps
    q_raw   = w_q ? XLEN'(dvd_n[31:0]) : dvd_n;
    q_fix   = neg_q_q ? (-q_raw) : q_raw;
    r_fix   = neg_r_q ? (-rem_n) : rem_n;
    sel     = is_rem_q ? r_fix : q_fix;
    fin     = w_q ? XLEN'($signed(sel[31:0])) : sel;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      result   <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      w_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_rem_q <= is_rem;
            neg_q_q  <= sign1 ^ sign2;
            neg_r_q  <= sign1;
            w_q      <= wop;
            if (div_zero || ovf || early) begin
              result <= spec_res;
              state  <= DONE;
            end else begin
              rem_q <= '0;
              dvd_q <= wop ? (mag1 << (XLEN - 32)) : mag1;
              dvs_q <= mag2;
              cnt_q <= wop ? 7'd31 : 7'(XLEN - 1);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem_q <= rem_n;
          dvd_q <= dvd_n;
          cnt_q <= cnt_q - 7'd1;
          if (cnt_q == '0) begin
            result <= fin;
            state  <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider (XLEN=64).
module tb_divider;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic        req_w;
  logic [63:0] req_op1;
  logic [63:0] req_op2;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] result;

  int errors = 0;
  int checks = 0;

`ifdef DIVIDER_EARLY_OUT_EN
  localparam int EO_LAT = 0;
`else
  localparam int EO_LAT = 64;
`endif

  localparam logic [2:0] F_DIV  = 3'd4;
  localparam logic [2:0] F_DIVU = 3'd5;
  localparam logic [2:0] F_REM  = 3'd6;
  localparam logic [2:0] F_REMU = 3'd7;

  divider #(.XLEN(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_w      (req_w),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Accept a request; lat = clock edges after the accept edge until res_valid
  task automatic issue(input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b, output int lat);
    @(negedge clock);
    req_funct3 = f3;
    req_w      = w;
    req_op1    = a;
    req_op2    = b;
    req_valid  = 1'b1;
    @(posedge clock);
    #1;
    req_valid  = 1'b0;
    req_op1    = 64'hDEAD_BEEF_0BAD_F00D;
    req_op2    = 64'h0000_0000_0000_0003;
    req_funct3 = F_REM;
    req_w      = ~w;
    lat = 0;
    while (!res_valid && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    @(negedge clock);
    res_ready = 1'b1;
    @(posedge clock);
    #1;
    res_ready = 1'b0;
    chk64({tag, " ready after consume"}, 64'(req_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    issue(f3, w, a, b, lat);
    chk_int({tag, " latency"}, lat, exp_lat);
    chk64({tag, " result"}, result, exp);
    consume(tag);
  endtask

  initial begin
    int lat;
    logic seen;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_funct3 = '0;
    req_w      = 1'b0;
    req_op1    = '0;
    req_op2    = '0;
    res_ready  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk64("reset req_ready", 64'(req_ready), 64'd1);
    chk64("reset res_valid", 64'(res_valid), 64'd0);
    chk64("reset result", result, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op("divu 100/7", F_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 64);
    run_op("remu 100/7", F_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 64);
    run_op("div -7/2", F_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 64);
    run_op("rem -7/2", F_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 64);
    run_op("rem 7/-2", F_REM, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64);
    run_op("divu 5/0", F_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("remu 5/0", F_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 0);
    run_op("divw 5/2^32", F_DIV, 1'b1, 64'd5, 64'h0000_0001_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("div ovf", F_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 0);
    run_op("rem ovf", F_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, 0);
    run_op("divw ovf", F_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 0);
    run_op("divuw", F_DIVU, 1'b1, 64'h0000_0001_FFFF_FFFE, 64'd2,
           64'h0000_0000_7FFF_FFFF, 32);
    run_op("divu 3/10", F_DIVU, 1'b0, 64'd3, 64'd10, 64'd0, EO_LAT);
    run_op("rem -3/10", F_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10,
           64'hFFFF_FFFF_FFFF_FFFD, EO_LAT);

    // Result held while the consumer stalls
    issue(F_DIVU, 1'b0, 64'd100, 64'd7, lat);
    chk_int("hold latency", lat, 64);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      chk64("hold result", result, 64'd14);
      chk64("hold req_ready", 64'(req_ready), 64'd0);
    end
    consume("hold");

    // Reset mid-operation aborts without emitting a result
    @(negedge clock);
    req_funct3 = F_DIVU;
    req_w      = 1'b0;
    req_op1    = 64'd1000;
    req_op2    = 64'd3;
    req_valid  = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk64("abort req_ready", 64'(req_ready), 64'd1);
    chk64("abort res_valid", 64'(res_valid), 64'd0);
    chk64("abort result", result, 64'd0);
    seen = 1'b0;
    repeat (70) begin
      @(posedge clock);
      #1;
      if (res_valid) seen = 1'b1;
    end
    chk64("abort no late result", 64'(seen), 64'd0);

    run_op("post-abort divu", F_DIVU, 1'b0, 64'd1000, 64'd3, 64'd333, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Iterative multi-cycle integer divide unit for RV64M/RV32M: DIV, DIVU, REM, REMU and their W variants.
- Sits beside the combinational ALU in the execute stage and covers the operations the single-cycle ALU cannot.
- Radix-2 restoring algorithm, one quotient bit per clock.
- Valid/ready request and result handshakes let the pipeline stall on it.

Parameters:
- XLEN, 64, datapath width; legal values are 32 and 64.
- XMSB, XLEN-1, derived MSB index.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  divider can accept a request.
- req_funct3  in  3  RISC-V funct3: 4=DIV, 5=DIVU, 6=REM, 7=REMU; 0-3 illegal.
- req_w  in  1  32-bit W variant; ignored when XLEN=32.
- req_op1  in  XLEN  dividend (rs1).
- req_op2  in  XLEN  divisor (rs2).
- res_valid  out  1  result present.
- res_ready  in  1  consumer takes result.
- result  out  XLEN  quotient or remainder.

Behaviour:
- Reset: state=IDLE, req_ready=1, res_valid=0, result=0.
- Reset wins over every other event. Reset asserted in BUSY or DONE aborts the operation: IDLE on the next cycle, no result emitted.
- FSM states: IDLE, BUSY, DONE.
- req_ready = (state==IDLE). res_valid = (state==DONE).

IDLE -> BUSY on a clock edge with req_valid & req_ready:
- Latch the operation, sign mode (funct3[0]==0 means signed) and W.
- Operand preparation for W: low 32 bits of each operand, sign-extended if signed, zero-extended if unsigned.
- Signed mode: latch absolute values and record neg_q = sign(op1)^sign(op2) and neg_r = sign(op1). Signs are taken from bit 31 for W, otherwise bit XMSB.
- Iteration count N = 32 if W, else XLEN.

BUSY:
- Each edge shifts one dividend bit into the partial remainder.
- If partial remainder >= divisor: subtract it and shift in quotient bit 1; otherwise shift in 0.
- After the Nth iteration edge: apply sign fixup (negate quotient if neg_q, negate remainder if neg_r), select quotient (DIV/DIVU) or remainder (REM/REMU), sign-extend from bit 31 if W, register into result, go to DONE.
- Latency: res_valid is high exactly N cycles after the accept edge.

Special cases are detected at accept. They skip BUSY and go IDLE -> DONE in 1 cycle:
- Divisor == 0 (after W truncation): quotient = all ones; remainder = dividend (after W extension).
- Signed overflow, dividend = most-negative and divisor = -1 (at the W or full width): quotient = dividend; remainder = 0.
- Both cases still apply W sign-extension of the result.

DONE:
- result is held stable while res_ready=0.
- An edge with res_ready=1 returns to IDLE.
- No same-cycle result-consume plus new-accept: back-to-back throughput is N+2 cycles.

Other rules:
- Illegal funct3 (0-3) is treated as DIVU. Software must not issue it; the bench must not rely on it.
- Inputs are sampled only on the accept edge. Changes to req_* during BUSY or DONE are ignored.
- Negating the most-negative magnitude wraps modulo 2^N. This case only arises in the overflow path, which is handled above.

Optional Feature:
- Macro: DIVIDER_EARLY_OUT_EN.
- Defined: at accept, compare unsigned magnitudes. If |divisor| > |dividend| and the divisor is nonzero, go IDLE -> DONE in 1 cycle with quotient = 0 and remainder = original dividend (W-extended). The signed remainder keeps the dividend's sign.
- Not defined: these cases take the full N iterations. The result is bit-identical in both builds; only latency differs.

Test Plan:
- XLEN=64, DIVU op1=100 op2=7 -> result=14, res_valid exactly 64 cycles after accept. REMU with the same operands -> 2.
- DIV op1=-7 op2=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). REM op1=-7 op2=2 -> 0xFFFF_FFFF_FFFF_FFFF (-1). REM op1=7 op2=-2 -> 1.
- Divide by zero:
  - DIVU 5/0 -> 0xFFFF_FFFF_FFFF_FFFF in 1 cycle.
  - REMU 5/0 -> 5.
  - DIVW 5/0x1_0000_0000 -> divisor truncates to 0 -> 0xFFFF_FFFF_FFFF_FFFF.
- Overflow:
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000, REM -> 0, both in 1 cycle.
  - DIVW 0x8000_0000 / 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
- DIVUW op1=0x0000_0001_FFFF_FFFE op2=2 -> 0x0000_0000_7FFF_FFFF after 32 cycles.
- Control:
  - Hold res_ready=0 for 10 cycles in DONE -> result stable, req_ready=0.
  - Assert reset at BUSY cycle 20 -> IDLE next cycle, res_valid=0, req_ready=1.
  - With DIVIDER_EARLY_OUT_EN, DIVU 3/10 -> quotient 0 in 1 cycle.
